// File: rtl/led_matrix_pkg.sv
// Shared types and widths for the 64x32 LED matrix pixel path.
package led_matrix_pkg;
  localparam int ROW_W      = 5;
  localparam int COL_W      = 6;
  localparam int PIX_ADDR_W = ROW_W + COL_W;
  localparam int CH_W       = 6;
  localparam int PIX_W      = 3 * CH_W;

  // Packed MSB-first so the 18-bit word reads {blue, green, red}.
  typedef struct packed {
    logic [CH_W-1:0] blue;
    logic [CH_W-1:0] green;
    logic [CH_W-1:0] red;
  } pixel_t;

  typedef enum logic {
    SW_IDLE    = 1'b0,
    SW_PENDING = 1'b1
  } swap_state_e;
endpackage

// File: rtl/fb_bank_ctrl.sv
// Front/back bank selection: swaps are deferred to the next frame boundary.
module fb_bank_ctrl
  import led_matrix_pkg::*;
(
  input  logic clk_in,
  input  logic reset,
  input  logic swap_req,
  input  logic scan_frame_end,
  output logic swap_pending,
  output logic display_bank
);
  swap_state_e r_state, w_next;
  logic        r_bank;
  logic        w_toggle;

  always_comb begin
    w_next   = r_state;
    w_toggle = 1'b0;
    case (r_state)
      SW_IDLE: begin
        // A request landing on the frame boundary swaps at once.
        if (swap_req && scan_frame_end) w_toggle = 1'b1;
        else if (swap_req)              w_next   = SW_PENDING;
      end
      SW_PENDING: begin
        if (scan_frame_end) begin
          w_toggle = 1'b1;
          w_next   = SW_IDLE;
        end
      end
      default: w_next = SW_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state <= SW_IDLE;
      r_bank  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_toggle) r_bank <= ~r_bank;
    end
  end

  assign swap_pending = (r_state == SW_PENDING);
  assign display_bank = r_bank;
endmodule

// File: rtl/framebuffer_arbiter.sv
// Single-port pixel RAM arbiter: scan reads have priority, host writes are
// forced through after STARVE_LIMIT refused cycles.
module framebuffer_arbiter
  import led_matrix_pkg::*;
#(
  parameter int ADDR_W       = PIX_ADDR_W,
  parameter int DATA_W       = PIX_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic              scan_ack,
  output logic              scan_rvalid,
  output logic [DATA_W-1:0] scan_rdata,
  input  logic              scan_frame_end,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              swap_req,
  output logic              swap_pending,
  output logic              display_bank,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W:0]   ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             r_rvalid;
  logic             w_wr_elig, w_force_wr, w_gnt_wr, w_gnt_scan;
  logic             w_swap_pending, w_bank;

  fb_bank_ctrl u_bank (
    .clk_in         (clk_in),
    .reset          (reset),
    .swap_req       (swap_req),
    .scan_frame_end (scan_frame_end),
    .swap_pending   (w_swap_pending),
    .display_bank   (w_bank)
  );

  // Writes are held off while a swap is pending so the back bank stays
  // frozen until it becomes the front bank.
  assign w_wr_elig  = wr_valid && !w_swap_pending;
  assign w_force_wr = (r_starve_cnt == LIMIT);
  assign w_gnt_wr   = reset && w_wr_elig && (w_force_wr || !scan_req);
  assign w_gnt_scan = reset && scan_req && !w_gnt_wr;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_starve_cnt <= '0;
      r_rvalid     <= 1'b0;
    end else begin
      r_rvalid <= w_gnt_scan;
      if (w_gnt_wr || w_swap_pending)
        r_starve_cnt <= '0;
      else if (wr_valid && r_starve_cnt != LIMIT)
        r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  assign scan_ack     = w_gnt_scan;
  assign wr_ready     = w_gnt_wr;
  assign scan_rvalid  = r_rvalid;
  assign scan_rdata   = ram_rdata;
  assign swap_pending = w_swap_pending;
  assign display_bank = w_bank;

  assign ram_en    = w_gnt_wr || w_gnt_scan;
  assign ram_we    = w_gnt_wr;
  assign ram_addr  = w_gnt_wr ? {~w_bank, wr_addr} : {w_bank, scan_addr};
  assign ram_wdata = wr_data;
endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Bench for framebuffer_arbiter: vector table, directed corner sequences and
// randomized traffic against a cycle-level reference model.
module tb_framebuffer_arbiter;
  localparam int AW = 11;
  localparam int DW = 18;
  localparam int LIM = 4;

  logic          clk_in = 1'b0;
  logic          reset;
  logic          scan_req, scan_ack, scan_rvalid, scan_frame_end;
  logic [AW-1:0] scan_addr, wr_addr;
  logic [DW-1:0] scan_rdata, wr_data, ram_wdata, ram_rdata;
  logic          wr_valid, wr_ready, swap_req, swap_pending, display_bank;
  logic          ram_en, ram_we;
  logic [AW:0]   ram_addr;

  always #5 clk_in = ~clk_in;

  framebuffer_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk_in(clk_in), .reset(reset),
    .scan_req(scan_req), .scan_addr(scan_addr), .scan_ack(scan_ack),
    .scan_rvalid(scan_rvalid), .scan_rdata(scan_rdata),
    .scan_frame_end(scan_frame_end),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .swap_req(swap_req), .swap_pending(swap_pending), .display_bank(display_bank),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Pixel RAM with registered read; pl_* preloads words during reset.
  logic [DW-1:0] ram [4096];
  logic          pl_en;
  logic [AW:0]   pl_addr;
  logic [DW-1:0] pl_data;
  always @(posedge clk_in) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram[ram_addr];
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: bank/swap bookkeeping and how long the writer has waited.
  logic           m_bank, m_pend, m_prev_ack, m_rd_known;
  int             m_wait;
  logic [DW-1:0]  m_rd;
  logic [DW-1:0]  m_mem [int];
  logic           e_scan, e_wr;

  task automatic model_step();
    logic elig, forced;
    if (!reset) begin
      m_bank = 0; m_pend = 0; m_wait = 0; m_prev_ack = 0;
    end
    elig   = wr_valid && !m_pend;
    forced = (m_wait >= LIM);
    e_wr   = reset && elig && (forced || !scan_req);
    e_scan = reset && scan_req && !e_wr;
    chk("scan_ack", scan_ack, e_scan);
    chk("wr_ready", wr_ready, e_wr);
    chk("ram_en", ram_en, e_scan || e_wr);
    chk("ram_we", ram_we, e_wr);
    if (e_wr)   chk("wr_addr_out", ram_addr, {~m_bank, wr_addr});
    if (e_wr)   chk("ram_wdata", ram_wdata, wr_data);
    if (e_scan) chk("rd_addr_out", ram_addr, {m_bank, scan_addr});
    chk("swap_pending", swap_pending, m_pend);
    chk("display_bank", display_bank, m_bank);
    chk("scan_rvalid", scan_rvalid, m_prev_ack);
    if (m_prev_ack && m_rd_known) chk("scan_rdata", scan_rdata, m_rd);
    if (pl_en) m_mem[int'(pl_addr)] = pl_data;
    if (!reset) return;
    // Effects of the upcoming clock edge.
    if (e_wr) m_mem[int'({~m_bank, wr_addr})] = wr_data;
    if (e_scan) begin
      m_rd_known = m_mem.exists(int'({m_bank, scan_addr}));
      if (m_rd_known) m_rd = m_mem[int'({m_bank, scan_addr})];
    end
    m_prev_ack = e_scan;
    if (e_wr || m_pend)     m_wait = 0;
    else if (elig)          m_wait = (m_wait + 1 > LIM) ? LIM : m_wait + 1;
    if (m_pend) begin
      if (scan_frame_end) begin m_bank = ~m_bank; m_pend = 0; end
    end else if (swap_req) begin
      if (scan_frame_end) m_bank = ~m_bank;
      else                m_pend = 1;
    end
  endtask

  task automatic cycle();
    @(negedge clk_in);
    model_step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_in();
    scan_req = 0; wr_valid = 0; swap_req = 0; scan_frame_end = 0;
    scan_addr = '0; wr_addr = '0; wr_data = '0;
  endtask

  typedef struct {
    logic          sreq, wv;
    logic [AW-1:0] sa, wa;
    logic [DW-1:0] wd;
    logic          x_ack, x_rdy;
    logic [AW:0]   x_addr;
  } vec_t;
  vec_t tbl [10];

  initial begin
    // Starvation break: four scan cycles, then the writer is forced through.
    for (int i = 0; i < 4; i++) tbl[i] = '{1, 1, 11'h010, 11'h020, 18'h00AA, 1, 0, 12'h010};
    tbl[4] = '{1, 1, 11'h010, 11'h020, 18'h00AA, 0, 1, 12'h820};
    tbl[5] = '{1, 0, 11'h010, 11'h000, 18'h0000, 1, 0, 12'h010};
    // Idle writes land in the back bank every cycle.
    tbl[6] = '{0, 1, 11'h000, 11'h100, 18'h11111, 0, 1, 12'h900};
    tbl[7] = '{0, 1, 11'h000, 11'h101, 18'h22222, 0, 1, 12'h901};
    tbl[8] = '{0, 1, 11'h000, 11'h102, 18'h33333, 0, 1, 12'h902};
    tbl[9] = '{1, 1, 11'h100, 11'h103, 18'h00001, 1, 0, 12'h100};

    m_rd_known = 0; m_rd = '0; e_scan = 0; e_wr = 0;
    idle_in();
    pl_en = 1; pl_addr = 12'h005; pl_data = 18'h3F000;
    reset = 0;
    scan_req = 1; wr_valid = 1; scan_addr = 11'h7FF; wr_addr = 11'h001;
    cycle();
    chk("rst_ram_en", ram_en, 0);
    chk("rst_bank", display_bank, 0);
    pl_en = 0;
    idle_in();
    cycle();
    reset = 1;
    scan_req = 1; scan_addr = 11'h0AB;
    @(negedge clk_in);
    chk("post_rst_ack", scan_ack, 1);
    chk("post_rst_addr", ram_addr, 12'h0AB);
    model_step(); @(posedge clk_in); #1;

    // Scan read latency against the preloaded word.
    scan_req = 1; scan_addr = 11'h005;
    cycle();
    scan_req = 0;
    @(negedge clk_in);
    chk("lat_rvalid", scan_rvalid, 1);
    chk("lat_rdata", scan_rdata, 18'h3F000);
    model_step(); @(posedge clk_in); #1;

    for (int i = 0; i < 10; i++) begin
      scan_req = tbl[i].sreq; wr_valid = tbl[i].wv; scan_addr = tbl[i].sa;
      wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      @(negedge clk_in);
      chk($sformatf("tbl%0d_ack", i), scan_ack, tbl[i].x_ack);
      chk($sformatf("tbl%0d_rdy", i), wr_ready, tbl[i].x_rdy);
      chk($sformatf("tbl%0d_addr", i), ram_addr, tbl[i].x_addr);
      model_step(); @(posedge clk_in); #1;
    end
    idle_in();
    cycle();

    // Deferred swap: writer blocked while pending, back bank flips after.
    swap_req = 1;
    cycle();
    swap_req = 0; wr_valid = 1; wr_addr = 11'h033; wr_data = 18'h15555;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      chk("def_pending", swap_pending, 1);
      chk("def_wr_blocked", wr_ready, 0);
      model_step(); @(posedge clk_in); #1;
    end
    wr_valid = 0; scan_frame_end = 1;
    cycle();
    scan_frame_end = 0; wr_valid = 1;
    @(negedge clk_in);
    chk("def_bank", display_bank, 1);
    chk("def_wr_bank0", ram_addr, 12'h033);
    model_step(); @(posedge clk_in); #1;
    idle_in();

    // Coincident swap, then a repeated request while pending.
    swap_req = 1; scan_frame_end = 1;
    @(negedge clk_in);
    chk("coin_pend", swap_pending, 0);
    model_step(); @(posedge clk_in); #1;
    swap_req = 0; scan_frame_end = 0;
    @(negedge clk_in);
    chk("coin_bank", display_bank, 0);
    chk("coin_pend2", swap_pending, 0);
    model_step(); @(posedge clk_in); #1;
    swap_req = 1; cycle(); cycle();
    swap_req = 0; scan_frame_end = 1; cycle();
    scan_frame_end = 0;
    @(negedge clk_in);
    chk("dbl_bank", display_bank, 1);
    model_step(); @(posedge clk_in); #1;

    // Reset mid-read drops rvalid, pending swap and the bank.
    swap_req = 1; cycle();
    swap_req = 0; scan_req = 1; scan_addr = 11'h005; cycle();
    reset = 0; scan_req = 0;
    @(negedge clk_in);
    chk("mid_rvalid", scan_rvalid, 0);
    chk("mid_pend", swap_pending, 0);
    chk("mid_bank", display_bank, 0);
    model_step(); @(posedge clk_in); #1;
    reset = 1;
    cycle();

    // Randomized traffic with valid/req held while refused.
    for (int i = 0; i < 600; i++) begin
      if (!(scan_req && !e_scan)) begin
        scan_req  = ($urandom_range(0, 3) != 0);
        scan_addr = AW'($urandom_range(0, 31));
      end
      if (!(wr_valid && !e_wr)) begin
        wr_valid = $urandom_range(0, 1) == 1;
        wr_addr  = AW'($urandom_range(0, 31));
        wr_data  = DW'($urandom);
      end
      swap_req       = ($urandom_range(0, 19) == 0);
      scan_frame_end = ($urandom_range(0, 24) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
